cl_divider: RTL and testbench

CL_DIVIDER -- requirements
Module: cl_divider

---
 rtl/cl_div_pkg.sv | 25 ++
 rtl/cl_divider_msb_index.sv | 28 ++
 rtl/cl_divider.sv | 184 ++++++++++++++++++
 tb/tb_cl_divider.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_div_pkg.sv
// ----------------------------------------------------------------------------
// cl_div_pkg
// Shared definitions for the cl_divider block: FSM state encoding, default
// divisor width and the iteration-counter width helper.
// No ports (package).
// ----------------------------------------------------------------------------
package cl_div_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefDataWidth = 4;

    // The counter runs over 2W steps; one spare bit keeps the terminal
    // comparison free of wrap-around corner cases.
    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(2 * data_width) + 1;
    endfunction

    localparam int unsigned DefCntWidth = cnt_width(DefDataWidth);

endpackage

// File: rtl/cl_divider_msb_index.sv
// ----------------------------------------------------------------------------
// msb_index
// Combinational priority encoder returning the index of the most significant
// set bit of i_value. Returns 0 when i_value is 0 (callers treat that case
// separately).
// Ports:
//   i_value  [Width-1:0]  operand
//   o_index  [IdxW-1:0]   index of highest set bit
// ----------------------------------------------------------------------------
module msb_index #(
    parameter int unsigned Width = 4,
    parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] i_value,
    output logic [IdxW-1:0]  o_index
);

    // Ascending scan: the last hit is the highest set bit.
    always_comb begin
        o_index = '0;
        for (int i = 0; i < Width; i++) begin
            if (i_value[i]) begin
                o_index = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/cl_divider.sv
// ----------------------------------------------------------------------------
// cl_divider
// Sequential restoring divider of a 2W-bit dividend by a W-bit divisor.
// carry_option=0 performs carry-less (GF(2) polynomial) division,
// carry_option=1 performs unsigned integer division. One dividend bit is
// consumed per cycle, MSB first, so a result takes 2W cycles in RUN.
// A zero divisor skips RUN and reports div_by_zero on the next edge.
// Ports:
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   start         request a division (accepted in IDLE or DONE only)
//   carry_option  0 = carry-less, 1 = integer; sampled with start
//   dividend      [2W-1:0] sampled with start
//   divisor       [W-1:0]  sampled with start
//   busy          high while in RUN
//   done          one-cycle pulse when results are valid
//   quotient      [2W-1:0] registered result
//   remainder     [W-1:0]  registered result
//   div_by_zero   registered flag, valid with done
// ----------------------------------------------------------------------------
module cl_divider
    import cl_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      carry_option,
    input  logic [2*DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH-1:0]     divisor,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]     remainder,
    output logic                      div_by_zero
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = cnt_width(DATA_WIDTH);
    localparam int unsigned IdxW = (W > 1) ? $clog2(W) : 1;

    state_e            r_state;
    state_e            w_state_next;

    logic [2*W-1:0]    r_dividend;
    logic [2*W-1:0]    r_quo;
    logic [W-1:0]      r_divisor;
    logic              r_mode;
    logic [IdxW-1:0]   r_msb;
    logic [W:0]        r_rem;
    logic [CntW-1:0]   r_cnt;

    logic              w_accept;
    logic              w_zero_div;
    logic              w_last;
    logic [IdxW-1:0]   w_msb;
    logic [W:0]        w_shift;
    logic [W:0]        w_rem_next;
    logic              w_qbit;
    logic [2*W-1:0]    w_quo_next;
    logic              w_unused;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign w_accept   = start && ((r_state == StIdle) || (r_state == StDone));
    assign w_zero_div = (divisor == '0);
    assign w_last     = (r_cnt == CntW'(2 * W - 1));

    assign busy = (r_state == StRun);
    assign done = (r_state == StDone);

    // The reduced remainder always fits in W bits, so its top bit and the
    // quotient bit shifted out on the final step are never consumed.
    assign w_unused = r_rem[W] ^ r_quo[2*W-1];

    msb_index #(
        .Width (W),
        .IdxW  (IdxW)
    ) u_msb_index (
        .i_value (divisor),
        .o_index (w_msb)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = w_zero_div ? StDone : StRun;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    w_state_next = w_zero_div ? StDone : StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // One division step
    // -------------------------------------------------------------------------
    always_comb begin
        w_shift    = {r_rem[W-1:0], r_dividend[2*W-1]};
        w_rem_next = w_shift;
        w_qbit     = 1'b0;
        if (r_mode) begin
            if (w_shift >= {1'b0, r_divisor}) begin
                w_rem_next = w_shift - {1'b0, r_divisor};
                w_qbit     = 1'b1;
            end
        end else begin
            // GF(2): reduce whenever the term at the divisor's degree appears.
            if (w_shift[r_msb]) begin
                w_rem_next = w_shift ^ {1'b0, r_divisor};
                w_qbit     = 1'b1;
            end
        end
        w_quo_next = {r_quo[2*W-2:0], w_qbit};
    end

    // -------------------------------------------------------------------------
    // Datapath and result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dividend  <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_mode      <= 1'b0;
            r_msb       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_dividend  <= dividend;
            r_quo       <= '0;
            r_divisor   <= divisor;
            r_mode      <= carry_option;
            r_msb       <= w_msb;
            r_rem       <= '0;
            r_cnt       <= '0;
            div_by_zero <= 1'b0;
            if (w_zero_div) begin
                quotient    <= '1;
                remainder   <= dividend[W-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (r_state == StRun) begin
            r_dividend <= r_dividend << 1;
            r_rem      <= w_rem_next;
            r_quo      <= w_quo_next;
            r_cnt      <= r_cnt + CntW'(1);
            if (w_last) begin
                quotient  <= w_quo_next;
                remainder <= w_rem_next[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cl_divider.sv
module tb_cl_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         carry_option;
    logic [7:0]   dividend;
    logic [3:0]   divisor;
    logic         busy;
    logic         done;
    logic [7:0]   quotient;
    logic [3:0]   remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    cl_divider #(
        .DATA_WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .carry_option (carry_option),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference division from first principles: {quotient, remainder}.
    function automatic logic [11:0] ref_div(input logic mode, input logic [7:0] a,
                                            input logic [3:0] b);
        logic [7:0] q;
        logic [7:0] rem;
        int deg;
        if (b == 4'd0) return {8'hFF, a[3:0]};
        if (mode) begin
            q   = a / {4'b0, b};
            rem = a % {4'b0, b};
            return {q, rem[3:0]};
        end
        deg = 0;
        for (int i = 0; i < 4; i++) if (b[i]) deg = i;
        rem = a;
        q   = 8'd0;
        for (int i = 7; i >= deg; i--) begin
            if (rem[i]) begin
                rem      = rem ^ ({4'b0, b} << (i - deg));
                q[i-deg] = 1'b1;
            end
        end
        return {q, rem[3:0]};
    endfunction

    // Cycle-level behavioural model: counts remaining RUN cycles only.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic       m_dbz  = 1'b0;
    logic [7:0] m_q    = 8'd0;
    logic [3:0] m_r    = 4'd0;
    logic [7:0] m_pq   = 8'd0;
    logic [3:0] m_pr   = 4'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= 8'd0;
            m_r    <= 4'd0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= 1'b0;
            if (m_left == 1) begin
                m_q    <= m_pq;
                m_r    <= m_pr;
                m_done <= 1'b1;
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_dbz <= 1'b0;
                if (divisor == 4'd0) begin
                    m_q    <= 8'hFF;
                    m_r    <= dividend[3:0];
                    m_dbz  <= 1'b1;
                    m_done <= 1'b1;
                end else begin
                    {m_pq, m_pr} <= ref_div(carry_option, dividend, divisor);
                    m_left       <= 2 * W;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_busy", {31'd0, busy}, {31'd0, m_left != 0});
            check("cmp_done", {31'd0, done}, {31'd0, m_done});
            check("cmp_quotient", {24'd0, quotient}, {24'd0, m_q});
            check("cmp_remainder", {28'd0, remainder}, {28'd0, m_r});
            check("cmp_div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    // t_acc is the cycle count right after the sampling edge.
    task automatic start_op(input logic mode, input logic [7:0] a, input logic [3:0] b,
                            output int t_acc);
        carry_option = mode;
        dividend     = a;
        divisor      = b;
        start        = 1'b1;
        t_acc        = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat = edges after the sampling edge until done is visible.
    task automatic wait_done(input int t_acc, input string nm, output int lat);
        while (done !== 1'b1 && (cyc - t_acc) < 40) @(negedge clk);
        lat = cyc - t_acc;
        check({nm, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_case(input logic mode, input logic [7:0] a, input logic [3:0] b,
                            input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                            input int elat, input string nm);
        logic [11:0] ref_v;
        int t;
        int lat;
        ref_v = ref_div(mode, a, b);
        check({nm, "_model_q"}, {24'd0, ref_v[11:4]}, {24'd0, eq});
        check({nm, "_model_r"}, {28'd0, ref_v[3:0]}, {28'd0, er});
        start_op(mode, a, b, t);
        wait_done(t, nm, lat);
        check({nm, "_latency"}, lat, elat);
        check({nm, "_q"}, {24'd0, quotient}, {24'd0, eq});
        check({nm, "_r"}, {28'd0, remainder}, {28'd0, er});
        check({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        @(negedge clk);
        check({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int t;
        int lat;
        logic seen;
        rst_n        = 1'b0;
        start        = 1'b0;
        carry_option = 1'b0;
        dividend     = 8'd0;
        divisor      = 4'd0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", {24'd0, quotient}, 32'd0);
        check("rst_r", {28'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_case(1'b0, 8'd120, 4'd10, 8'd12, 4'd0, 1'b0, 8, "cl_120_10");
        // Carry-less 46/9 leaves x+1 as remainder; integer 46/9 leaves 1.
        run_case(1'b0, 8'd46, 4'd9, 8'd5, 4'd3, 1'b0, 8, "cl_46_9");
        run_case(1'b1, 8'd46, 4'd9, 8'd5, 4'd1, 1'b0, 8, "int_46_9");
        run_case(1'b0, 8'd75, 4'd13, 8'd15, 4'd0, 1'b0, 8, "cl_75_13");
        run_case(1'b1, 8'd75, 4'd13, 8'd5, 4'd10, 1'b0, 8, "int_75_13");
        run_case(1'b0, 8'h2A, 4'd0, 8'hFF, 4'hA, 1'b1, 0, "div0");
        run_case(1'b1, 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, "int_255_1");
        run_case(1'b0, 8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, "cl_255_1");
        run_case(1'b1, 8'd200, 4'd15, 8'd13, 4'd5, 1'b0, 8, "int_200_15");

        // start re-asserted in RUN cycle 3 with different operands
        start_op(1'b1, 8'd75, 4'd13, t);
        @(negedge clk);
        @(negedge clk);
        carry_option = 1'b0;
        dividend     = 8'h99;
        divisor      = 4'd3;
        start        = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'h11;
        divisor  = 4'd0;
        wait_done(t, "ignore", lat);
        check("ignore_latency", lat, 8);
        check("ignore_q", {24'd0, quotient}, 32'd5);
        check("ignore_r", {28'd0, remainder}, 32'd10);
        @(negedge clk);

        // back-to-back: second start issued in the DONE cycle
        start_op(1'b0, 8'd120, 4'd10, t);
        wait_done(t, "b2b_a", lat);
        check("b2b_a_q", {24'd0, quotient}, 32'd12);
        start_op(1'b1, 8'd46, 4'd9, t);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(t, "b2b_b", lat);
        check("b2b_b_latency", lat, 8);
        check("b2b_b_q", {24'd0, quotient}, 32'd5);
        check("b2b_b_r", {28'd0, remainder}, 32'd1);
        @(negedge clk);

        // reset mid-RUN aborts with no done pulse and clears outputs
        start_op(1'b1, 8'd200, 4'd15, t);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", {24'd0, quotient}, 32'd0);
        check("abort_r", {28'd0, remainder}, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);

        run_case(1'b1, 8'd200, 4'd15, 8'd13, 4'd5, 1'b0, 8, "after_abort");

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
